// File: rtl/div_pkg.sv
// ---------------------------------------------------------------------------
// div_pkg
// Shared definitions for the pipelined divider:
//   - default widths for the dividend/quotient, divisor/remainder and tag
//   - datapath_len(): partial-remainder width derived from the operand widths
//   - occupancy encodings, which double as the stage FSM state encodings so
//     the occupancy output can be driven straight from the state register
// ---------------------------------------------------------------------------
package div_pkg;

    localparam int DIV_DIVIDENDLEN = 16;
    localparam int DIV_DIVISORLEN  = 8;
    localparam int DIV_TAGLEN      = 4;

    localparam logic [1:0] OCC_EMPTY = 2'd0;
    localparam logic [1:0] OCC_ONE   = 2'd1;
    localparam logic [1:0] OCC_FULL  = 2'd2;

    typedef enum logic [1:0] {
        ST_EMPTY = OCC_EMPTY,
        ST_ONE   = OCC_ONE,
        ST_FULL  = OCC_FULL
    } occ_state_e;

    function automatic int datapath_len(input int a, input int b);
        return a + b - 1;
    endfunction

endpackage

// File: rtl/div_stage_reg.sv
// ---------------------------------------------------------------------------
// div_stage_reg
// Registered pipeline stage between divider slices. Holds up to two
// in-flight division tokens (main + skid) so that in_ready can be a flop
// while still sustaining one token per cycle.
//
// Ports:
//   clock, reset_n          rising-edge clock, async active-low reset
//   flush                   synchronous discard of all held tokens
//   in_valid / in_ready     upstream handshake (in_ready registered)
//   in_din/divin/qin/tag/dbz token fields from the upstream slice
//   out_valid / out_ready   downstream handshake
//   out_dout/divout/qout/tag/dbz  token held in the main register
//   occupancy               number of held tokens (0, 1, 2)
// ---------------------------------------------------------------------------
module div_stage_reg
    import div_pkg::*;
#(
    parameter int DIVIDENDLEN = DIV_DIVIDENDLEN,
    parameter int DIVISORLEN  = DIV_DIVISORLEN,
    parameter int TAGLEN      = DIV_TAGLEN,
    localparam int DATAPATHLEN = datapath_len(DIVIDENDLEN, DIVISORLEN)
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATAPATHLEN-1:0] in_din,
    input  logic [DIVISORLEN-1:0]  in_divin,
    input  logic [DIVIDENDLEN-1:0] in_qin,
    input  logic [TAGLEN-1:0]      in_tag,
    input  logic                   in_dbz,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATAPATHLEN-1:0] out_dout,
    output logic [DIVISORLEN-1:0]  out_divout,
    output logic [DIVIDENDLEN-1:0] out_qout,
    output logic [TAGLEN-1:0]      out_tag,
    output logic                   out_dbz,
    output logic [1:0]             occupancy
);

    typedef struct packed {
        logic [DATAPATHLEN-1:0] dp;
        logic [DIVISORLEN-1:0]  div;
        logic [DIVIDENDLEN-1:0] q;
        logic [TAGLEN-1:0]      tag;
        logic                   dbz;
    } div_token_t;

    occ_state_e state_r;
    occ_state_e state_next_s;
    div_token_t main_r;
    div_token_t main_next_s;
    div_token_t skid_r;
    div_token_t skid_next_s;
    div_token_t in_tok_s;
    logic       in_ready_r;
    logic       in_ready_next_s;
    logic       accept_s;
    logic       emit_s;
    logic       main_valid_s;

    // A zero divisor is flagged here so later slices never need to re-detect it.
    assign in_tok_s = '{dp:  in_din,
                        div: in_divin,
                        q:   in_qin,
                        tag: in_tag,
                        dbz: in_dbz | (in_divin == {DIVISORLEN{1'b0}})};

    assign main_valid_s = (state_r != ST_EMPTY);
    assign accept_s     = in_valid & in_ready_r;
    assign emit_s       = main_valid_s & out_ready;

    // Next-state and next-data selection for the occupancy FSM.
    always_comb begin
        state_next_s = state_r;
        main_next_s  = main_r;
        skid_next_s  = skid_r;
        if (flush) begin
            // Only the valid state is dropped; data registers keep their contents.
            state_next_s = ST_EMPTY;
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    if (accept_s) begin
                        state_next_s = ST_ONE;
                        main_next_s  = in_tok_s;
                    end else begin
                        state_next_s = ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    if (accept_s && emit_s) begin
                        // Replace main in place: no bubble on streaming traffic.
                        state_next_s = ST_ONE;
                        main_next_s  = in_tok_s;
                    end else if (accept_s) begin
                        state_next_s = ST_FULL;
                        skid_next_s  = in_tok_s;
                    end else if (emit_s) begin
                        state_next_s = ST_EMPTY;
                    end else begin
                        state_next_s = ST_ONE;
                    end
                end
                ST_FULL: begin
                    // in_ready is low here, so only the skid-to-main move can happen.
                    if (emit_s) begin
                        state_next_s = ST_ONE;
                        main_next_s  = skid_r;
                    end else begin
                        state_next_s = ST_FULL;
                    end
                end
                default: begin
                    state_next_s = ST_EMPTY;
                end
            endcase
        end
        // Ready is low exactly while the skid entry will be occupied.
        in_ready_next_s = (state_next_s != ST_FULL);
    end

    // State, ready and token registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r    <= ST_EMPTY;
            in_ready_r <= 1'b0;
            main_r     <= '0;
            skid_r     <= '0;
        end else begin
            state_r    <= state_next_s;
            in_ready_r <= in_ready_next_s;
            main_r     <= main_next_s;
            skid_r     <= skid_next_s;
        end
    end

    assign in_ready   = in_ready_r;
    assign out_valid  = main_valid_s;
    assign out_dout   = main_r.dp;
    assign out_divout = main_r.div;
    assign out_qout   = main_r.q;
    assign out_tag    = main_r.tag;
    assign out_dbz    = main_r.dbz;
    assign occupancy  = state_r;

endmodule
